// File: rtl/cnn_pkg.sv
// Shared constants, FSM encoding and sign-extension helpers for the CNN
// fully-connected classifier stage.
package cnn_pkg;

  localparam int N_FEAT        = 784;
  localparam int N_CLASS       = 10;
  localparam int FEAT_ADDR_LEN = 9;
  localparam int W_ADDR_LEN    = 12;
  localparam int ACC_W         = 25;
  localparam int BIAS_BASE     = N_CLASS * N_FEAT;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BIAS  = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_CMP   = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  function automatic logic signed [ACC_W-1:0] sext8(input logic signed [7:0] v);
    return {{(ACC_W-8){v[7]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] sext16(input logic signed [15:0] v);
    return {{(ACC_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running argmax over class scores; strict greater-than keeps the lowest
// class index on ties.
module argmax_tracker
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    cmp,
  input  logic signed [ACC_W-1:0] acc,
  input  logic [3:0]              cls,
  output logic signed [ACC_W-1:0] next_score,
  output logic [3:0]              next_id
);

  localparam logic signed [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] best_score_r;
  logic [3:0]              best_id_r;

  // Value the tracker will hold after this cycle's compare strobe.
  always_comb begin
    next_score = best_score_r;
    next_id    = best_id_r;
    if (cmp && (acc > best_score_r)) begin
      next_score = acc;
      next_id    = cls;
    end else begin
      next_score = best_score_r;
      next_id    = best_id_r;
    end
  end

  // Best-so-far registers, re-armed at the most negative score on start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_score_r <= {ACC_W{1'b0}};
      best_id_r    <= 4'd0;
    end else if (clear) begin
      best_score_r <= MOST_NEG;
      best_id_r    <= 4'd0;
    end else begin
      best_score_r <= next_score;
      best_id_r    <= next_id;
    end
  end

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected classifier: one sequential int8 MAC over 784 features per
// class, bias preload, running argmax, registered result with a done pulse.
module fc_classifier
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    feat_rd,
  output logic [FEAT_ADDR_LEN:0]  feat_addr,
  input  logic signed [7:0]       feat_data,
  output logic                    w_rd,
  output logic [W_ADDR_LEN:0]     w_addr,
  input  logic signed [7:0]       w_data,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              class_id,
  output logic [ACC_W-1:0]        score
);

  localparam int FA_W = FEAT_ADDR_LEN + 1;
  localparam int WA_W = W_ADDR_LEN + 1;
  localparam logic [FA_W-1:0] K_LAST     = FA_W'(N_FEAT - 1);
  localparam logic [3:0]      C_LAST     = 4'(N_CLASS - 1);
  localparam logic [WA_W-1:0] BIAS_ADDR0 = WA_W'(BIAS_BASE);
  localparam logic [WA_W-1:0] FEAT_STEP  = WA_W'(N_FEAT);

  logic [2:0]              state_r;
  logic [3:0]              c_r;
  logic [FA_W-1:0]         k_r;
  logic [WA_W-1:0]         wbase_r;
  logic                    drain_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    feat_rd_r;
  logic                    w_rd_r;
  logic [FA_W-1:0]         feat_addr_r;
  logic [WA_W-1:0]         w_addr_r;
  logic [3:0]              class_id_r;
  logic signed [ACC_W-1:0] score_r;

  logic                    bias_d1_r;
  logic                    rd_d1_r;
  logic                    prod_v_r;
  logic signed [15:0]      prod_r;
  logic signed [ACC_W-1:0] acc_r;

  logic                    clear_s;
  logic                    cmp_s;
  logic signed [ACC_W-1:0] next_score_s;
  logic [3:0]              next_id_s;

  assign clear_s = (state_r == ST_IDLE) && start;
  assign cmp_s   = (state_r == ST_CMP);

  argmax_tracker u_argmax (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_s),
    .cmp        (cmp_s),
    .acc        (acc_r),
    .cls        (c_r),
    .next_score (next_score_s),
    .next_id    (next_id_s)
  );

  // Control FSM: sequencing, registered read strobes/addresses, result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      c_r         <= 4'd0;
      k_r         <= {FA_W{1'b0}};
      wbase_r     <= {WA_W{1'b0}};
      drain_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      feat_rd_r   <= 1'b0;
      w_rd_r      <= 1'b0;
      feat_addr_r <= {FA_W{1'b0}};
      w_addr_r    <= {WA_W{1'b0}};
      class_id_r  <= 4'd0;
      score_r     <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            c_r      <= 4'd0;
            wbase_r  <= {WA_W{1'b0}};
            busy_r   <= 1'b1;
            w_rd_r   <= 1'b1;
            w_addr_r <= BIAS_ADDR0;
            state_r  <= ST_BIAS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BIAS: begin
          k_r         <= {FA_W{1'b0}};
          feat_rd_r   <= 1'b1;
          w_rd_r      <= 1'b1;
          feat_addr_r <= {FA_W{1'b0}};
          w_addr_r    <= wbase_r;
          state_r     <= ST_MAC;
        end
        ST_MAC: begin
          if (k_r == K_LAST) begin
            feat_rd_r <= 1'b0;
            w_rd_r    <= 1'b0;
            drain_r   <= 1'b0;
            state_r   <= ST_DRAIN;
          end else begin
            k_r         <= k_r + FA_W'(1);
            feat_addr_r <= k_r + FA_W'(1);
            w_addr_r    <= w_addr_r + WA_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_r) begin
            state_r <= ST_CMP;
          end else begin
            drain_r <= 1'b1;
          end
        end
        ST_CMP: begin
          // Capture the post-compare best so class_id/score are valid with done.
          if (c_r == C_LAST) begin
            class_id_r <= next_id_s;
            score_r    <= next_score_s;
            done_r     <= 1'b1;
            state_r    <= ST_FIN;
          end else begin
            c_r      <= c_r + 4'd1;
            wbase_r  <= wbase_r + FEAT_STEP;
            w_rd_r   <= 1'b1;
            w_addr_r <= BIAS_ADDR0 + WA_W'(c_r) + WA_W'(1);
            state_r  <= ST_BIAS;
          end
        end
        ST_FIN: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          feat_rd_r <= 1'b0;
          w_rd_r    <= 1'b0;
          done_r    <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  // MAC pipeline: operand-valid tracking, registered product, accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bias_d1_r <= 1'b0;
      rd_d1_r   <= 1'b0;
      prod_v_r  <= 1'b0;
      prod_r    <= 16'sd0;
      acc_r     <= {ACC_W{1'b0}};
    end else begin
      bias_d1_r <= (state_r == ST_BIAS);
      rd_d1_r   <= feat_rd_r;
      prod_v_r  <= rd_d1_r;
      if (rd_d1_r) begin
        prod_r <= feat_data * w_data;
      end else begin
        prod_r <= prod_r;
      end
      if (bias_d1_r) begin
        acc_r <= sext8(w_data);
      end else if (prod_v_r) begin
        acc_r <= acc_r + sext16(prod_r);
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign feat_rd   = feat_rd_r;
  assign feat_addr = feat_addr_r;
  assign w_rd      = w_rd_r;
  assign w_addr    = w_addr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign class_id  = class_id_r;
  assign score     = score_r;

endmodule
